// File: rtl/minimips_bus_pkg.sv
// Shared types for the miniMIPS bus arbiter: the bus phase encoding and the index-width helper.
package minimips_bus_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_START = 3'd3,
    ST_NOOP  = 3'd4
  } state_t;

  // A single master still needs a 1-bit index so that the ports stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/minimips_rr_picker.sv
// Round-robin pick: rotate req so the bit after rr_ptr sits at 0, take the lowest set bit, rotate back.
module minimips_rr_picker
  import minimips_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  localparam int IDX_W = idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [IDX_W-1:0]       pick,
  output logic                   valid
);

  logic [IDX_W:0]         sh;
  logic [IDX_W:0]         enc;
  logic [IDX_W:0]         sum;
  logic [NUM_MASTERS-1:0] rot;

  always_comb begin
    // sh lies in 1..NUM_MASTERS; a shift of NUM_MASTERS on {req,req} is the identity rotation.
    sh  = (IDX_W+1)'(rr_ptr) + (IDX_W+1)'(1);
    rot = NUM_MASTERS'({req, req} >> sh);
    enc = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (rot[i]) enc = (IDX_W+1)'(i);
    end
    sum = enc + sh;
    if (sum >= (IDX_W+1)'(NUM_MASTERS)) sum = sum - (IDX_W+1)'(NUM_MASTERS);
    pick  = IDX_W'(sum);
    valid = |req;
  end

endmodule

// File: rtl/minimips_bus_arbiter.sv
// N-master round-robin arbiter and ADDR/DATA phase sequencer for the miniMIPS system bus,
// with a wait-cycle timeout that forces stalled transfers back to arbitration.
module minimips_bus_arbiter
  import minimips_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IDX_W = idx_w(NUM_MASTERS)
) (
  input  logic                   UFRGS_miniMIPS_clock,
  input  logic                   UFRGS_miniMIPS_reset,
  input  logic [NUM_MASTERS-1:0] UFRGS_miniMIPS_req,
  output logic [NUM_MASTERS-1:0] UFRGS_miniMIPS_gnt,
  output logic [IDX_W-1:0]       UFRGS_miniMIPS_gnt_idx,
  output logic                   UFRGS_miniMIPS_start,
  input  logic                   UFRGS_miniMIPS_bip,
  input  logic                   UFRGS_miniMIPS_wait,
  input  logic                   UFRGS_miniMIPS_error,
  output logic                   UFRGS_miniMIPS_rw_park,
  output logic                   UFRGS_miniMIPS_timeout,
  output logic                   UFRGS_miniMIPS_busy
);

  localparam int TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TCNT_W-1:0] TMO_AT = TCNT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state, state_n;
  logic [IDX_W-1:0]       rr_ptr, rr_ptr_n, pick;
  logic [TCNT_W-1:0]      tcnt, tcnt_n;
  logic [NUM_MASTERS-1:0] gnt_n;
  logic [IDX_W-1:0]       gnt_idx_n;
  logic                   start_n, rw_park_n, timeout_n, pick_valid, tmo, data_exit;

  minimips_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req    (UFRGS_miniMIPS_req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .valid  (pick_valid)
  );

  assign tmo = (TIMEOUT_CYCLES != 0) && (tcnt == TMO_AT) && UFRGS_miniMIPS_wait;
  assign data_exit = UFRGS_miniMIPS_error || (!UFRGS_miniMIPS_bip && !UFRGS_miniMIPS_wait) || tmo;
  assign UFRGS_miniMIPS_busy = (state == ST_ADDR) || (state == ST_DATA);

  always_comb begin
    state_n   = state;
    start_n   = 1'b0;
    rw_park_n = 1'b0;
    timeout_n = 1'b0;
    gnt_n     = UFRGS_miniMIPS_gnt;
    gnt_idx_n = UFRGS_miniMIPS_gnt_idx;
    rr_ptr_n  = rr_ptr;
    tcnt_n    = tcnt;

    // Arbitration happens on the edge that closes the start strobe.
    if (UFRGS_miniMIPS_start) begin
      if (pick_valid) begin
        gnt_n     = NUM_MASTERS'(1) << pick;
        gnt_idx_n = pick;
        rr_ptr_n  = pick;
      end else begin
        gnt_n = '0;
      end
    end

    case (state)
      ST_INIT: begin
        state_n = ST_START;
        start_n = 1'b1;
      end
      ST_START: begin
        if (gnt_n != '0) begin
          state_n = ST_ADDR;
        end else begin
          state_n   = ST_NOOP;
          rw_park_n = 1'b1;
        end
      end
      ST_NOOP: begin
        state_n = ST_START;
        start_n = 1'b1;
      end
      ST_ADDR: begin
        state_n = ST_DATA;
        tcnt_n  = '0;
      end
      ST_DATA: begin
        if (UFRGS_miniMIPS_wait && (tcnt != '1)) tcnt_n = tcnt + TCNT_W'(1);
        if (data_exit) begin
          state_n   = ST_START;
          start_n   = 1'b1;
          gnt_n     = '0;
          timeout_n = tmo;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge UFRGS_miniMIPS_clock or posedge UFRGS_miniMIPS_reset) begin
    if (UFRGS_miniMIPS_reset) begin
      state                  <= ST_INIT;
      UFRGS_miniMIPS_start   <= 1'b0;
      UFRGS_miniMIPS_gnt     <= '0;
      UFRGS_miniMIPS_gnt_idx <= '0;
      UFRGS_miniMIPS_rw_park <= 1'b0;
      UFRGS_miniMIPS_timeout <= 1'b0;
      rr_ptr                 <= IDX_W'(NUM_MASTERS - 1);
      tcnt                   <= '0;
    end else begin
      state                  <= state_n;
      UFRGS_miniMIPS_start   <= start_n;
      UFRGS_miniMIPS_gnt     <= gnt_n;
      UFRGS_miniMIPS_gnt_idx <= gnt_idx_n;
      UFRGS_miniMIPS_rw_park <= rw_park_n;
      UFRGS_miniMIPS_timeout <= timeout_n;
      rr_ptr                 <= rr_ptr_n;
      tcnt                   <= tcnt_n;
    end
  end

endmodule
